// File: rtl/iic_reg_bank.sv
// Byte-wide register bank behind the IIC slave: control/status, TX/RX FIFOs
// and an edge-triggered interrupt controller.
module iic_reg_bank #(
    parameter int          IADDR_WIDTH = 8,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [7:0]  ID_VALUE    = 8'hA5,
    parameter logic [7:0]  CTRL_RST    = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IADDR_WIDTH-1:0] s_address,
    input  logic [7:0]             s_writedata,
    input  logic                   s_write,
    input  logic                   s_read,
    output logic [7:0]             s_readdata,
    output logic [7:0]             ctrl_o,
    input  logic [7:0]             stat_i,
    input  logic [7:0]             irq_src_i,
    output logic                   irq_o,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [IADDR_WIDTH-1:0] addr_t;

    localparam addr_t A_ID   = addr_t'(0);
    localparam addr_t A_SCR  = addr_t'(1);
    localparam addr_t A_CTRL = addr_t'(2);
    localparam addr_t A_STAT = addr_t'(3);
    localparam addr_t A_PEND = addr_t'(4);
    localparam addr_t A_EN   = addr_t'(5);
    localparam addr_t A_TXD  = addr_t'(6);
    localparam addr_t A_TXS  = addr_t'(7);
    localparam addr_t A_RXD  = addr_t'(8);
    localparam addr_t A_RXS  = addr_t'(9);

    logic [7:0]    scratch;
    logic [7:0]    pend;
    logic [7:0]    en;
    logic [7:0]    prev;
    logic [7:0]    rdata;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [CW-1:0] tx_count;
    logic          tx_ovf;
    logic          tx_full;
    logic          tx_req;
    logic          tx_push;
    logic          tx_pop;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [CW-1:0] rx_count;
    logic          rx_udf;
    logic          rx_empty;
    logic          rx_rd;
    logic          rx_push;
    logic          rx_pop;

    logic          wr_scr;
    logic          wr_ctrl;
    logic          wr_pend;
    logic          wr_en;
    logic          wr_txs;
    logic          wr_rxs;

    assign wr_scr  = s_write && (s_address == A_SCR);
    assign wr_ctrl = s_write && (s_address == A_CTRL);
    assign wr_pend = s_write && (s_address == A_PEND);
    assign wr_en   = s_write && (s_address == A_EN);
    assign wr_txs  = s_write && (s_address == A_TXS);
    assign wr_rxs  = s_write && (s_address == A_RXS);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_mem[tx_rptr];
    assign tx_req   = s_write && (s_address == A_TXD);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_push  = tx_req && (!tx_full || tx_pop);

    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != CW'(FIFO_DEPTH));
    assign rx_push  = rx_valid && rx_ready;
    assign rx_rd    = s_read && (s_address == A_RXD);
    assign rx_pop   = rx_rd && !rx_empty;

    always_comb begin
        rdata = 8'h00;
        case (s_address)
            A_ID:    rdata = ID_VALUE;
            A_SCR:   rdata = scratch;
            A_CTRL:  rdata = ctrl_o;
            A_STAT:  rdata = stat_i;
            A_PEND:  rdata = pend;
            A_EN:    rdata = en;
            A_TXS:   rdata = {tx_ovf, 1'b0, 6'(tx_count)};
            A_RXD:   rdata = rx_empty ? 8'h00 : rx_mem[rx_rptr];
            A_RXS:   rdata = {rx_udf, 1'b0, 6'(rx_count)};
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_readdata <= 8'h00;
            scratch    <= 8'h00;
            ctrl_o     <= CTRL_RST;
            en         <= 8'h00;
            pend       <= 8'h00;
            prev       <= 8'h00;
            irq_o      <= 1'b0;
        end else begin
            if (s_read)
                s_readdata <= rdata;
            if (wr_scr)
                scratch <= s_writedata;
            if (wr_ctrl)
                ctrl_o <= s_writedata;
            if (wr_en)
                en <= s_writedata;
            prev <= irq_src_i;
            // New edges are OR-ed in after the clear so a set wins.
            pend <= (pend & ~(wr_pend ? s_writedata : 8'h00))
                  | (irq_src_i & ~prev);
            irq_o <= |(pend & en);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wptr] <= s_writedata;
        if (rx_push)
            rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (tx_push)
                tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)
                tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)
                tx_count <= tx_count + CW'(1);
            else if (!tx_push && tx_pop)
                tx_count <= tx_count - CW'(1);
            if (wr_txs && s_writedata[7])
                tx_ovf <= 1'b0;
            if (tx_req && !tx_push)
                tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            rx_udf   <= 1'b0;
        end else begin
            if (rx_push)
                rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)
                rx_rptr <= rx_rptr + AW'(1);
            if (rx_push && !rx_pop)
                rx_count <= rx_count + CW'(1);
            else if (!rx_push && rx_pop)
                rx_count <= rx_count - CW'(1);
            if (wr_rxs && s_writedata[7])
                rx_udf <= 1'b0;
            if (rx_rd && rx_empty)
                rx_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iic_reg_bank.sv
// Directed bench for iic_reg_bank: register reads go through a scoreboard
// queue checked by a monitor; stream and IRQ outputs are checked in place.
module tb_iic_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_address;
    logic [7:0] s_writedata;
    logic       s_write;
    logic       s_read;
    logic [7:0] s_readdata;
    logic [7:0] ctrl_o;
    logic [7:0] stat_i;
    logic [7:0] irq_src_i;
    logic       irq_o;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic       rd_q = 1'b0;

    iic_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .s_address  (s_address),
        .s_writedata(s_writedata),
        .s_write    (s_write),
        .s_read     (s_read),
        .s_readdata (s_readdata),
        .ctrl_o     (ctrl_o),
        .stat_i     (stat_i),
        .irq_src_i  (irq_src_i),
        .irq_o      (irq_o),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= s_read;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every registered read strobe presents one readdata byte.
    always @(negedge clk) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underrun: got %0h expected none", s_readdata);
            end else begin
                chk("readdata", {24'h0, s_readdata}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        cyc();
        s_write     = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        s_address = a;
        s_read    = 1'b1;
        exp_q.push_back(e);
        cyc();
        s_read    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_address = '0; s_writedata = '0; s_write = 0; s_read = 0;
        stat_i = '0; irq_src_i = '0; tx_ready = 0;
        rx_data = '0; rx_valid = 0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_rdata", {24'h0, s_readdata}, 32'h00);
        chk("rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("rst_rxr", {31'h0, rx_ready}, 32'h1);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        chk("rst_ctrl", {24'h0, ctrl_o}, 32'h00);

        rd(8'h00, 8'hA5);
        rd(8'h01, 8'h00);
        rd(8'h02, 8'h00);
        wr(8'h02, 8'h3C);
        chk("ctrl_o", {24'h0, ctrl_o}, 32'h3C);
        rd(8'h02, 8'h3C);
        wr(8'h01, 8'h5A);
        rd(8'h01, 8'h5A);
        stat_i = 8'h96;
        rd(8'h03, 8'h96);
        wr(8'h00, 8'h12);
        rd(8'h00, 8'hA5);
        rd(8'h20, 8'h00);
        rd(8'h06, 8'h00);

        // write and read of SCRATCH in one cycle returns the old value
        s_address = 8'h01; s_writedata = 8'h99;
        s_write = 1'b1; s_read = 1'b1;
        exp_q.push_back(8'h5A);
        cyc();
        s_write = 1'b0; s_read = 1'b0;
        rd(8'h01, 8'h99);

        wr(8'h06, 8'h11);
        wr(8'h06, 8'h22);
        wr(8'h06, 8'h33);
        rd(8'h07, 8'h03);
        tx_ready = 1'b1;
        chk("tx_d0", {24'h0, tx_data}, 32'h11);
        cyc();
        chk("tx_d1", {24'h0, tx_data}, 32'h22);
        cyc();
        chk("tx_d2", {24'h0, tx_data}, 32'h33);
        cyc();
        chk("tx_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        for (int i = 0; i < 17; i++)
            wr(8'h06, 8'(i));
        rd(8'h07, 8'h90);
        wr(8'h07, 8'h80);
        rd(8'h07, 8'h10);
        tx_ready = 1'b1;
        wr(8'h06, 8'hEE);
        tx_ready = 1'b0;
        chk("tx_full_pp", {24'h0, tx_data}, 32'h01);
        rd(8'h07, 8'h10);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_txv", {31'h0, tx_valid}, 32'h0);
        chk("mid_rxr", {31'h0, rx_ready}, 32'h1);
        chk("mid_ctrl", {24'h0, ctrl_o}, 32'h00);
        rd(8'h07, 8'h00);

        rd(8'h08, 8'h00);
        rd(8'h09, 8'h80);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        cyc();
        rx_data  = 8'h6B;
        cyc();
        rx_valid = 1'b0;
        rd(8'h09, 8'h82);
        rd(8'h08, 8'h5A);
        rd(8'h08, 8'h6B);
        wr(8'h09, 8'h80);
        rd(8'h09, 8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        rd(8'h08, 8'h00);
        rx_valid = 1'b0;
        rd(8'h09, 8'h81);
        rd(8'h08, 8'h77);
        rd(8'h09, 8'h80);

        wr(8'h05, 8'h01);
        irq_src_i = 8'h01;
        cyc();
        chk("irq_n1", {31'h0, irq_o}, 32'h0);
        cyc();
        chk("irq_n2", {31'h0, irq_o}, 32'h1);
        irq_src_i = 8'h00;
        rd(8'h04, 8'h01);
        wr(8'h04, 8'h01);
        cyc();
        chk("irq_clr", {31'h0, irq_o}, 32'h0);
        rd(8'h04, 8'h00);

        irq_src_i = 8'h01;
        cyc();
        irq_src_i = 8'h00;
        cyc();
        irq_src_i = 8'h01;
        wr(8'h04, 8'h01);
        irq_src_i = 8'h00;
        rd(8'h04, 8'h01);
        chk("irq_setwin", {31'h0, irq_o}, 32'h1);

        cyc();
        cyc();
        cyc();
        chk("sb_drain", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
